// File: rtl/spi_slave_if_if.sv
// SPI slave bus bundle: serial pins toward the SPI master plus the RAM-side
// command (rx_*) and read-response (tx_*) signals.
interface spi_slave_if_if #(
  parameter int ADDR_SIZE = 8,
  parameter int TX_WIDTH  = 8
);
  // Handshake: rx_valid and tx_valid are single-cycle strobes with no ready;
  // the consumer must take rx_data/tx_data in the cycle its strobe is high.
  logic                 mosi;
  logic                 ss_n;
  logic                 miso;
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [TX_WIDTH-1:0]  tx_data;
  logic                 tx_valid;

  modport slave (
    input  mosi, ss_n, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );

  modport master (
    output mosi, ss_n, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: deserialises MOSI frames into
// command words and serialises RAM read data on MISO. Optional SPI_FRAME_ERR_EN.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8,
  parameter int TX_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_slave_if_if.slave        bus,
  output logic [2:0]           state_dbg,
  output logic                 rd_addr_flag_dbg
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int W  = ADDR_SIZE + 2;
  localparam int CW = $clog2(W + 1);
  localparam int TW = $clog2(TX_WIDTH + 1);

  localparam logic [CW-1:0] CNT_DONE = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [TW-1:0] TX_REST  = TW'(TX_WIDTH - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  logic [2:0]          state;
  logic [CW-1:0]       bit_cnt;
  logic [W-2:0]        rx_shift;
  logic [W-1:0]        rx_data_q;
  logic                rx_valid_q;
  logic                rd_addr_flag;
  logic [TX_WIDTH-2:0] tx_shift;
  logic [TW-1:0]       tx_cnt;
  logic                tx_busy;
  logic                tx_done;
  logic                miso_q;

  logic rx_active;
  logic rx_last;
  logic abort;

  always_comb begin
    rx_active = ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA))
                && (bit_cnt != CNT_DONE);
    rx_last   = rx_active && (bit_cnt == CNT_LAST);
    abort     = (state != IDLE) && bus.ss_n;
  end

`ifdef SPI_FRAME_ERR_EN
  logic tx_pending;
  logic abort_err;

  // Once the last MISO bit is on the line the transmit counts as delivered.
  always_comb begin
    tx_pending = (state == READ_DATA) && (bit_cnt == CNT_DONE) && !tx_done
                 && !(tx_busy && (tx_cnt == '0));
    abort_err  = abort && ((state == CHK_CMD) || rx_active || tx_pending);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort_err;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (abort) begin
        // Slave deselected: drop any partial frame or transmit immediately.
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        tx_cnt   <= '0;
        tx_busy  <= 1'b0;
        tx_done  <= 1'b0;
        miso_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            miso_q  <= 1'b0;
            if (!bus.ss_n) begin
              state <= CHK_CMD;
            end
          end

          CHK_CMD: begin
            if (!bus.mosi) begin
              state <= WRITE;
            end else if (rd_addr_flag) begin
              state <= READ_DATA;
            end else begin
              state <= READ_ADD;
            end
          end

          WRITE, READ_ADD, READ_DATA: begin
            if (rx_active) begin
              rx_shift <= {rx_shift[W-3:0], bus.mosi};
              bit_cnt  <= bit_cnt + CW'(1);
              if (rx_last) begin
                rx_data_q  <= {rx_shift, bus.mosi};
                rx_valid_q <= 1'b1;
                if (state == READ_ADD) begin
                  rd_addr_flag <= 1'b1;
                end else if (state == READ_DATA) begin
                  rd_addr_flag <= 1'b0;
                end
              end
            end else if (state == READ_DATA) begin
              if (tx_busy) begin
                if (tx_cnt != '0) begin
                  miso_q   <= tx_shift[TX_WIDTH-2];
                  tx_shift <= {tx_shift[TX_WIDTH-3:0], 1'b0};
                  tx_cnt   <= tx_cnt - TW'(1);
                end else begin
                  miso_q  <= 1'b0;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
                end
              end else if (!tx_done && bus.tx_valid) begin
                // MSB goes out on the same edge the response is captured.
                miso_q   <= bus.tx_data[TX_WIDTH-1];
                tx_shift <= bus.tx_data[TX_WIDTH-2:0];
                tx_cnt   <= TX_REST;
                tx_busy  <= 1'b1;
              end
            end
          end

          default: begin
            state   <= IDLE;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.miso         = miso_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign state_dbg        = state;
  assign rd_addr_flag_dbg = rd_addr_flag;

endmodule
